// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encoding,
// ALU operation codes, opcode/funct values and datapath select values.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    // What the ALU is being used for in the current state
    typedef enum logic [2:0] {
        CLS_IDLE, CLS_PC, CLS_ADDR, CLS_R, CLS_I, CLS_CMP
    } alu_cls_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SRL  = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_RS    = 2'd1;
    localparam logic [1:0] SRC_A_SHAMT = 2'd2;
    localparam logic [1:0] SRC_A_C16   = 2'd3;
    localparam logic [1:0] SRC_B_RT    = 2'd0;
    localparam logic [1:0] SRC_B_4     = 2'd1;
    localparam logic [1:0] SRC_B_IMM   = 2'd2;
    localparam logic [1:0] SRC_B_BR    = 2'd3;
    localparam logic [1:0] DST_RT      = 2'd0;
    localparam logic [1:0] DST_RD      = 2'd1;
    localparam logic [1:0] DST_R31     = 2'd2;
    localparam logic [1:0] WB_ALUOUT   = 2'd0;
    localparam logic [1:0] WB_MDR      = 2'd1;
    localparam logic [1:0] WB_PC       = 2'd2;
    localparam logic [1:0] PC_ALU      = 2'd0;
    localparam logic [1:0] PC_ALUOUT   = 2'd1;
    localparam logic [1:0] PC_JUMP     = 2'd2;
    localparam logic [1:0] PC_RS       = 2'd3;

    // R-type functs that execute through R_EXEC (jr is routed separately)
    function automatic logic r_funct_ok(input logic [5:0] f);
        case (f)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
            FN_XOR, FN_SLT, FN_SLTU: r_funct_ok = 1'b1;
            default:                 r_funct_ok = 1'b0;
        endcase
    endfunction

    // Immediate-ALU opcodes handled by I_EXEC
    function automatic logic i_op_ok(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: i_op_ok = 1'b1;
            default:                          i_op_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// ALU control bus between the control FSM (master) and the datapath (slave).
// The datapath returns the ALU zero flag on the same bus.
interface mips_multicycle_ctrl_if;
    logic [3:0] ctrl_alu;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] pc_src;
    logic       zero;

    modport master (output ctrl_alu, alu_src_a, alu_src_b, imm_zext, pc_src, input zero);
    modport slave  (input ctrl_alu, alu_src_a, alu_src_b, imm_zext, pc_src, output zero);
endinterface

// File: rtl/mips_multicycle_ctrl_alu_op_decode.sv
// Combinational ALU operation and operand-A select from the state class
// plus the instruction's opcode/funct.
module alu_op_decode
    import mips_ctrl_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] ctrl_alu,
    output logic [1:0] alu_src_a
);

    // Per-class ALU op; idle states leave add/PC so the bus reads zero
    always_comb begin
        ctrl_alu  = ALU_ADD;
        alu_src_a = SRC_A_PC;
        case (cls)
            CLS_ADDR: alu_src_a = SRC_A_RS;
            CLS_CMP: begin
                alu_src_a = SRC_A_RS;
                ctrl_alu  = ALU_SUB;
            end
            CLS_R: begin
                alu_src_a = SRC_A_RS;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl_alu = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl_alu = ALU_SUB;
                    FN_SLL:  begin ctrl_alu = ALU_SLL; alu_src_a = SRC_A_SHAMT; end
                    FN_SRL:  begin ctrl_alu = ALU_SRL; alu_src_a = SRC_A_SHAMT; end
                    FN_SRA:  begin ctrl_alu = ALU_SRA; alu_src_a = SRC_A_SHAMT; end
                    FN_SLLV: ctrl_alu = ALU_SLL;
                    FN_SRLV: ctrl_alu = ALU_SRL;
                    FN_SRAV: ctrl_alu = ALU_SRA;
                    FN_SLT:  ctrl_alu = ALU_SLT;
                    FN_SLTU: ctrl_alu = ALU_SLTU;
                    FN_AND:  ctrl_alu = ALU_AND;
                    FN_OR:   ctrl_alu = ALU_OR;
                    FN_XOR:  ctrl_alu = ALU_XOR;
                    default: ctrl_alu = ALU_ADD;
                endcase
            end
            CLS_I: begin
                alu_src_a = SRC_A_RS;
                case (opcode)
                    OP_ADDI, OP_ADDIU: ctrl_alu = ALU_ADD;
                    OP_SLTI:  ctrl_alu = ALU_SLT;
                    OP_SLTIU: ctrl_alu = ALU_SLTU;
                    OP_ANDI:  ctrl_alu = ALU_AND;
                    OP_ORI:   ctrl_alu = ALU_OR;
                    OP_XORI:  ctrl_alu = ALU_XOR;
                    OP_LUI:   begin ctrl_alu = ALU_SLL; alu_src_a = SRC_A_C16; end
                    default:  ctrl_alu = ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM. Drives memory strobes, register-file and PC
// write enables, and the ALU control bus from the current state and IR fields.
// Optional feature macro: MIPS_CTRL_MEM_READY_EN (memory wait states).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic [3:0] state,
    output logic       illegal,
    mips_multicycle_ctrl_if.master alu_bus
);

    state_t     state_q, state_d;
    alu_cls_t   cls;
    logic [1:0] src_b, pc_src;
    logic       zext;
    logic [3:0] alu_op;
    logic [1:0] src_a;

    // Memory handshake: a memory state's strobe is held and the state does
    // not advance until mem_ready is sampled high on a rising edge.
    logic mem_go;
`ifdef MIPS_CTRL_MEM_READY_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign mem_go           = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= state_t'(RESET_STATE);
        else        state_q <= state_d;
    end

    // Next state and Moore outputs; everything is forced low while in reset
    always_comb begin
        state_d = state_q;
        pc_we   = 1'b0;
        ir_we   = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        iord    = 1'b0;
        reg_we  = 1'b0;
        reg_dst = DST_RT;
        wb_sel  = WB_ALUOUT;
        src_b   = SRC_B_RT;
        pc_src  = PC_ALU;
        zext    = 1'b0;
        illegal = 1'b0;
        cls     = CLS_IDLE;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_rd = 1'b1;
                    ir_we  = mem_go;
                    pc_we  = mem_go;
                    src_b  = SRC_B_4;
                    cls    = CLS_PC;
                    if (mem_go) state_d = S_DECODE;
                end
                S_DECODE: begin
                    src_b = SRC_B_BR;
                    cls   = CLS_PC;
                    case (opcode)
                        OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J, OP_JAL:   state_d = S_JUMP;
                        OP_RTYPE: begin
                            if (funct == FN_JR)         state_d = S_JUMP;
                            else if (r_funct_ok(funct)) state_d = S_R_EXEC;
                            else                        state_d = S_TRAP;
                        end
                        default: state_d = i_op_ok(opcode) ? S_I_EXEC : S_TRAP;
                    endcase
                end
                S_MEM_ADDR: begin
                    src_b   = SRC_B_IMM;
                    cls     = CLS_ADDR;
                    state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    iord   = 1'b1;
                    mem_rd = 1'b1;
                    if (mem_go) state_d = S_MEM_WB;
                end
                S_MEM_WB: begin
                    reg_we  = 1'b1;
                    reg_dst = DST_RT;
                    wb_sel  = WB_MDR;
                    state_d = S_FETCH;
                end
                S_MEM_WRITE: begin
                    iord   = 1'b1;
                    mem_wr = 1'b1;
                    if (mem_go) state_d = S_FETCH;
                end
                S_R_EXEC: begin
                    src_b   = SRC_B_RT;
                    cls     = CLS_R;
                    state_d = S_R_WB;
                end
                S_R_WB: begin
                    reg_we  = 1'b1;
                    reg_dst = DST_RD;
                    wb_sel  = WB_ALUOUT;
                    state_d = S_FETCH;
                end
                S_I_EXEC: begin
                    src_b   = SRC_B_IMM;
                    cls     = CLS_I;
                    zext    = (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                              (opcode == OP_XORI) || (opcode == OP_LUI);
                    state_d = S_I_WB;
                end
                S_I_WB: begin
                    reg_we  = 1'b1;
                    reg_dst = DST_RT;
                    state_d = S_FETCH;
                end
                S_BRANCH: begin
                    src_b   = SRC_B_RT;
                    cls     = CLS_CMP;
                    pc_src  = PC_ALUOUT;
                    pc_we   = (opcode == OP_BEQ) ? alu_bus.zero : ~alu_bus.zero;
                    state_d = S_FETCH;
                end
                S_JUMP: begin
                    pc_we  = 1'b1;
                    pc_src = (opcode == OP_RTYPE) ? PC_RS : PC_JUMP;
                    if (opcode == OP_JAL) begin
                        reg_we  = 1'b1;
                        reg_dst = DST_R31;
                        wb_sel  = WB_PC;
                    end
                    state_d = S_FETCH;
                end
                S_TRAP: illegal = 1'b1;
                default: state_d = S_TRAP;
            endcase
        end
    end

    alu_op_decode u_alu_op_decode (
        .cls       (cls),
        .opcode    (opcode),
        .funct     (funct),
        .ctrl_alu  (alu_op),
        .alu_src_a (src_a)
    );

    assign state             = state_q;
    assign alu_bus.ctrl_alu  = alu_op;
    assign alu_bus.alu_src_a = src_a;
    assign alu_bus.alu_src_b = src_b;
    assign alu_bus.imm_zext  = zext;
    assign alu_bus.pc_src    = pc_src;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class
// cycle by cycle and compares state plus every control output.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       mem_ready;
    logic       pc_we, ir_we, mem_rd, mem_wr, iord, reg_we, illegal;
    logic [1:0] reg_dst, wb_sel;
    logic [3:0] state;
    int         checks = 0;
    int         failures = 0;
    logic [21:0] v_fetch, v_decode, v_trap;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct     (funct),
        .mem_ready (mem_ready),
        .pc_we     (pc_we),
        .ir_we     (ir_we),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .iord      (iord),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wb_sel    (wb_sel),
        .state     (state),
        .illegal   (illegal),
        .alu_bus   (bus)
    );

    // clock
    always #5 clk = ~clk;

    // order: pc_we ir_we mem_rd mem_wr iord reg_we reg_dst wb_sel A B zext pc_src alu illegal
    function automatic logic [21:0] pk(input logic pw, iw, mr, mw, io, rw,
                                       input logic [1:0] rd, wb, a, b,
                                       input logic zx, input logic [1:0] ps,
                                       input logic [3:0] alu, input logic ill);
        return {pw, iw, mr, mw, io, rw, rd, wb, a, b, zx, ps, alu, ill};
    endfunction

    function automatic logic [25:0] observed();
        return {state, pc_we, ir_we, mem_rd, mem_wr, iord, reg_we, reg_dst, wb_sel,
                bus.alu_src_a, bus.alu_src_b, bus.imm_zext, bus.pc_src, bus.ctrl_alu, illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (observed() !== 26'd0) begin
            failures++;
            $display("FAIL reset_hold: got %h want %h", observed(), 26'd0);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (observed() !== {4'd0, v_fetch}) begin
            failures++;
            $display("FAIL reset_release: got %h want %h", observed(), {4'd0, v_fetch});
        end
    endtask

    task automatic test_lw();
        logic [25:0] e[$];
        opcode = 6'h23; funct = 6'h00;
        e = '{{4'd0, v_fetch}, {4'd1, v_decode},
              {4'd2, pk(0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2, 0,2'd0,4'd0,0)},
              {4'd3, pk(0,0,1,0,1,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0,4'd0,0)},
              {4'd4, pk(0,0,0,0,0,1, 2'd0,2'd1,2'd0,2'd0, 0,2'd0,4'd0,0)},
              {4'd0, v_fetch}};
        foreach (e[i]) begin
            checks++;
            if (observed() !== e[i]) begin
                failures++;
                $display("FAIL lw cycle %0d: got %h want %h", i, observed(), e[i]);
            end
            if (i != e.size() - 1) tick();
        end
    endtask

    task automatic test_r_type();
        logic [5:0]  fn[4];
        logic [21:0] ex[4];
        logic [25:0] e[$];
        fn = '{6'h03, 6'h2b, 6'h06, 6'h20};
        ex = '{pk(0,0,0,0,0,0, 2'd0,2'd0,2'd2,2'd0, 0,2'd0,4'd9,0),
               pk(0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0, 0,2'd0,4'd8,0),
               pk(0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0, 0,2'd0,4'd3,0),
               pk(0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0, 0,2'd0,4'd0,0)};
        for (int k = 0; k < 4; k++) begin
            opcode = 6'h00; funct = fn[k];
            e = '{{4'd0, v_fetch}, {4'd1, v_decode}, {4'd6, ex[k]},
                  {4'd7, pk(0,0,0,0,0,1, 2'd1,2'd0,2'd0,2'd0, 0,2'd0,4'd0,0)},
                  {4'd0, v_fetch}};
            foreach (e[i]) begin
                checks++;
                if (observed() !== e[i]) begin
                    failures++;
                    $display("FAIL r_type f=%h cycle %0d: got %h want %h", fn[k], i, observed(), e[i]);
                end
                if (i != e.size() - 1) tick();
            end
        end
    endtask

    task automatic test_i_type();
        logic [5:0]  op[4];
        logic [21:0] ex[4];
        logic [25:0] e[$];
        op = '{6'h0f, 6'h0c, 6'h0a, 6'h09};
        ex = '{pk(0,0,0,0,0,0, 2'd0,2'd0,2'd3,2'd2, 1,2'd0,4'd2,0),
               pk(0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2, 1,2'd0,4'd5,0),
               pk(0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2, 0,2'd0,4'd4,0),
               pk(0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2, 0,2'd0,4'd0,0)};
        for (int k = 0; k < 4; k++) begin
            opcode = op[k]; funct = 6'h15;
            e = '{{4'd0, v_fetch}, {4'd1, v_decode}, {4'd8, ex[k]},
                  {4'd9, pk(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 0,2'd0,4'd0,0)},
                  {4'd0, v_fetch}};
            foreach (e[i]) begin
                checks++;
                if (observed() !== e[i]) begin
                    failures++;
                    $display("FAIL i_type op=%h cycle %0d: got %h want %h", op[k], i, observed(), e[i]);
                end
                if (i != e.size() - 1) tick();
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0]  op[4];
        logic        zf[4];
        logic        pw[4];
        logic [25:0] e[$];
        op = '{6'h04, 6'h05, 6'h04, 6'h05};
        zf = '{1'b1, 1'b1, 1'b0, 1'b0};
        pw = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            opcode = op[k]; funct = 6'h00; bus.zero = zf[k];
            e = '{{4'd0, v_fetch}, {4'd1, v_decode},
                  {4'd10, pk(pw[k],0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0, 0,2'd1,4'd1,0)},
                  {4'd0, v_fetch}};
            foreach (e[i]) begin
                checks++;
                if (observed() !== e[i]) begin
                    failures++;
                    $display("FAIL branch op=%h zero=%0d cycle %0d: got %h want %h",
                             op[k], zf[k], i, observed(), e[i]);
                end
                if (i != e.size() - 1) tick();
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [5:0]  op[3];
        logic [5:0]  fn[3];
        logic [21:0] ex[3];
        logic [25:0] e[$];
        op = '{6'h02, 6'h03, 6'h00};
        fn = '{6'h00, 6'h00, 6'h08};
        ex = '{pk(1,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd2,4'd0,0),
               pk(1,0,0,0,0,1, 2'd2,2'd2,2'd0,2'd0, 0,2'd2,4'd0,0),
               pk(1,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd3,4'd0,0)};
        for (int k = 0; k < 3; k++) begin
            opcode = op[k]; funct = fn[k];
            e = '{{4'd0, v_fetch}, {4'd1, v_decode}, {4'd11, ex[k]}, {4'd0, v_fetch}};
            foreach (e[i]) begin
                checks++;
                if (observed() !== e[i]) begin
                    failures++;
                    $display("FAIL jump op=%h f=%h cycle %0d: got %h want %h",
                             op[k], fn[k], i, observed(), e[i]);
                end
                if (i != e.size() - 1) tick();
            end
        end
    endtask

    task automatic test_sw();
        logic [25:0] e_addr, e_wr;
        e_addr = {4'd2, pk(0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2, 0,2'd0,4'd0,0)};
        e_wr   = {4'd5, pk(0,0,0,1,1,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0,4'd0,0)};
        opcode = 6'h2b; funct = 6'h00;
`ifdef MIPS_CTRL_MEM_READY_EN
        // FETCH stalls with ir/pc writes suppressed while memory is busy
        mem_ready = 1'b0;
        tick();
        checks++;
        if (observed() !== {4'd0, pk(0,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd1, 0,2'd0,4'd0,0)}) begin
            failures++;
            $display("FAIL fetch_stall: got %h", observed());
        end
        mem_ready = 1'b1;
`endif
        tick();
        checks++;
        if (observed() !== {4'd1, v_decode}) begin
            failures++;
            $display("FAIL sw_decode: got %h want %h", observed(), {4'd1, v_decode});
        end
        tick();
        checks++;
        if (observed() !== e_addr) begin
            failures++;
            $display("FAIL sw_addr: got %h want %h", observed(), e_addr);
        end
        tick();
`ifdef MIPS_CTRL_MEM_READY_EN
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (observed() !== e_wr) begin
                failures++;
                $display("FAIL sw_wait %0d: got %h want %h", i, observed(), e_wr);
            end
            tick();
        end
        mem_ready = 1'b1;
`endif
        checks++;
        if (observed() !== e_wr) begin
            failures++;
            $display("FAIL sw_write: got %h want %h", observed(), e_wr);
        end
        tick();
        checks++;
        if (observed() !== {4'd0, v_fetch}) begin
            failures++;
            $display("FAIL sw_done: got %h want %h", observed(), {4'd0, v_fetch});
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'h23; funct = 6'h00;
        repeat (3) tick();
        checks++;
        if (observed() !== {4'd3, pk(0,0,1,0,1,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0,4'd0,0)}) begin
            failures++;
            $display("FAIL mid_read: got %h", observed());
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== 26'd0) begin
            failures++;
            $display("FAIL mid_reset_async: got %h want 0", observed());
        end
        tick();
        checks++;
        if (observed() !== 26'd0) begin
            failures++;
            $display("FAIL mid_reset_held: got %h want 0", observed());
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (observed() !== {4'd0, v_fetch}) begin
            failures++;
            $display("FAIL mid_restart: got %h want %h", observed(), {4'd0, v_fetch});
        end
        tick();
        checks++;
        if (observed() !== {4'd1, v_decode}) begin
            failures++;
            $display("FAIL mid_decode: got %h want %h", observed(), {4'd1, v_decode});
        end
        repeat (4) tick();
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("FAIL mid_finish: state %0d want 0", state);
        end
    endtask

    task automatic test_trap();
        logic [5:0] op[2];
        logic [5:0] fn[2];
        op = '{6'h3f, 6'h00};
        fn = '{6'h00, 6'h27};
        for (int k = 0; k < 2; k++) begin
            opcode = op[k]; funct = fn[k];
            tick();
            checks++;
            if (observed() !== {4'd1, v_decode}) begin
                failures++;
                $display("FAIL trap_decode op=%h: got %h", op[k], observed());
            end
            for (int c = 0; c < 20; c++) begin
                tick();
                checks++;
                if (observed() !== {4'd12, v_trap}) begin
                    failures++;
                    $display("FAIL trap op=%h f=%h cycle %0d: got %h want %h",
                             op[k], fn[k], c, observed(), {4'd12, v_trap});
                end
            end
            rst_n = 1'b0;
            #3;
            rst_n = 1'b1;
            #1;
            checks++;
            if (observed() !== {4'd0, v_fetch}) begin
                failures++;
                $display("FAIL trap_exit: got %h want %h", observed(), {4'd0, v_fetch});
            end
        end
    endtask

    // sequencer
    initial begin
        v_fetch  = pk(1,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd1, 0,2'd0,4'd0,0);
        v_decode = pk(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd3, 0,2'd0,4'd0,0);
        v_trap   = pk(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0,4'd0,1);
        rst_n = 1'b0;
        opcode = 6'h00;
        funct = 6'h00;
        bus.zero = 1'b0;
`ifdef MIPS_CTRL_MEM_READY_EN
        mem_ready = 1'b1;
`else
        mem_ready = 1'b0;
`endif
        test_reset();
        test_lw();
        test_r_type();
        test_i_type();
        test_branch();
        test_jump();
        test_sw();
        test_reset_mid();
        test_trap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
